// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // A divider with scale S produces a period of S + SCALE_OFFSET cycles.
    localparam int SCALE_OFFSET = 2;

    // Flops between the asynchronous input and the edge register.
    localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Synchronizes an asynchronous input and emits registered one-cycle rise/fall strobes.
module sync_edge
    import period_meter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Synchronizer chain, previous-value flop and registered edge strobes.
    // NOTE: every flop uses <= so all stages sample the pre-edge values; blocking
    // assignments here would collapse the chain into a single stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_bit;
            rise_q <= sync_bit & ~prev_q;
            fall_q <= ~sync_bit & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk_i cycles and
// reconstructs the divider scale word that would produce that period.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_WD = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sig_i,
    input  logic              en_i,
    output logic [CNT_WD-1:0] period_o,
    output logic [CNT_WD-1:0] high_o,
    output logic [CNT_WD-1:0] scale_o,
    output logic              valid_o,
    output logic              timeout_o
);

    localparam logic [CNT_WD-1:0] CNT_MAX = {CNT_WD{1'b1}};
    localparam logic [CNT_WD-1:0] OFFSET  = CNT_WD'(SCALE_OFFSET);

    state_t            state_q, state_d;
    logic              rise, fall;
    logic [CNT_WD-1:0] cnt_q, hi_q;
    logic [CNT_WD-1:0] period_q, high_q, scale_q;
    logic              valid_q;
    logic [CNT_WD-1:0] cnt_inc_val;
    logic              cnt_clr, cnt_inc, hi_upd, meas_upd;

    sync_edge u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sig_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    // The timeout at all-ones guarantees this never wraps in normal use.
    assign cnt_inc_val = cnt_q + CNT_WD'(1);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and counter/output control; a disable overrides every state.
    // NOTE: every signal assigned here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        hi_upd   = 1'b0;
        meas_upd = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_clr = 1'b1;
                end
                ARM: begin
                    if (rise) begin
                        cnt_clr = 1'b1;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        meas_upd = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        hi_upd = fall;
                        if (cnt_q == CNT_MAX) state_d = TIMEOUT;
                        else                  cnt_inc = 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (rise) begin
                        cnt_clr = 1'b1;
                        state_d = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Cycle counter and high-time capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            hi_q  <= '0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_inc_val;
            if (hi_upd)       hi_q  <= cnt_inc_val;
        end
    end

    // Measurement output registers; they hold between completed periods.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            high_q   <= '0;
            scale_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= meas_upd;
            if (meas_upd) begin
                period_q <= cnt_inc_val;
                high_q   <= hi_q;
                scale_q  <= (cnt_inc_val >= OFFSET) ? cnt_inc_val - OFFSET : '0;
            end
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign scale_o   = scale_q;
    assign valid_o   = valid_q;
    assign timeout_o = (state_q == TIMEOUT);

endmodule
